// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the general-purpose register file, also used by decode and hazard logic.
// Optional feature macro: REGFILE_BYPASS_EN (write-first read bypass).
package regfile_pkg;

  localparam int REGFILE_DEFAULT_WIDTH = 32;
  localparam int REGFILE_DEFAULT_DEPTH = 32;
  localparam int REGFILE_ZERO_ADDR     = 0;

  // Ceiling log2, usable in constant expressions for deriving address widths.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: entry select, hard-wired zero for entry 0, optional write-first bypass.
// Optional feature macro: REGFILE_BYPASS_EN (when defined, a same-cycle write to the read address is forwarded).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_DEFAULT_WIDTH,
  parameter int DEPTH = REGFILE_DEFAULT_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] entries_i,
  input  logic                        reset_i,
  input  logic                        write_en_i,
  input  logic [ADDR_W-1:0]           write_addr_i,
  input  logic [WIDTH-1:0]            write_data_i,
  input  logic [ADDR_W-1:0]           read_addr_i,
  output logic [WIDTH-1:0]            read_data_o
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REGFILE_ZERO_ADDR);

`ifdef REGFILE_BYPASS_EN
  logic bypassHit;

  // Forwarding is suppressed during reset so reads see stored contents only.
  assign bypassHit = !reset_i && write_en_i && (write_addr_i != ZeroAddr)
                     && (write_addr_i == read_addr_i);

  always_comb begin
    read_data_o = entries_i[read_addr_i];
    if (bypassHit) begin
      read_data_o = write_data_i;
    end
    if (read_addr_i == ZeroAddr) begin
      read_data_o = '0;
    end
  end
`else
  logic unusedBypass;

  assign unusedBypass = ^{reset_i, write_en_i, write_addr_i, write_data_i};

  always_comb begin
    read_data_o = entries_i[read_addr_i];
    if (read_addr_i == ZeroAddr) begin
      read_data_o = '0;
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: DEPTH entries, two combinational read ports, one write port, entry 0 reads zero.
// Optional feature macro: REGFILE_BYPASS_EN (write-first bypass on both read ports; default is read-old).
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_DEFAULT_WIDTH,
  parameter int DEPTH = REGFILE_DEFAULT_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_addr_a,
  output logic [WIDTH-1:0]  read_data_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  read_data_b
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REGFILE_ZERO_ADDR);

  logic [DEPTH-1:0][WIDTH-1:0] entries_q;
  logic [DEPTH-1:0][WIDTH-1:0] entries_d;
  logic [DEPTH-1:0]            writeSel;

  // One-hot write decode; address 0 never gets a select so writes to it vanish.
  always_comb begin
    writeSel = '0;
    if (write_en && (write_addr != ZeroAddr)) begin
      writeSel[write_addr] = 1'b1;
    end
  end

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (writeSel[i]) begin
        entries_d[i] = write_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  regfile_read_port #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) portA (
    .entries_i   (entries_q),
    .reset_i     (reset),
    .write_en_i  (write_en),
    .write_addr_i(write_addr),
    .write_data_i(write_data),
    .read_addr_i (read_addr_a),
    .read_data_o (read_data_a)
  );

  regfile_read_port #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) portB (
    .entries_i   (entries_q),
    .reset_i     (reset),
    .write_en_i  (write_en),
    .write_addr_i(write_addr),
    .write_data_i(write_data),
    .read_addr_i (read_addr_b),
    .read_data_o (read_data_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, corner sequences, then random traffic against an array model.
// Build with or without REGFILE_BYPASS_EN; expectations follow the macro.
module tb_register_file;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    string             name;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [WIDTH-1:0]  expA;
    logic [WIDTH-1:0]  expB;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              writeEn;
  logic [ADDR_W-1:0] writeAddr;
  logic [WIDTH-1:0]  writeData;
  logic [ADDR_W-1:0] readAddrA;
  logic [ADDR_W-1:0] readAddrB;
  logic [WIDTH-1:0]  readDataA;
  logic [WIDTH-1:0]  readDataB;

  int checkCount = 0;
  int failCount  = 0;

  logic [WIDTH-1:0] model [DEPTH];
  vec_t             vecs [$];

  always #5 clock = ~clock;

  register_file #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .write_en   (writeEn),
    .write_addr (writeAddr),
    .write_data (writeData),
    .read_addr_a(readAddrA),
    .read_data_a(readDataA),
    .read_addr_b(readAddrB),
    .read_data_b(readDataB)
  );

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic we, input logic [ADDR_W-1:0] waddr,
                               input logic [WIDTH-1:0] wdata, input logic [ADDR_W-1:0] ra,
                               input logic [ADDR_W-1:0] rb);
    reset     = rst;
    writeEn   = we;
    writeAddr = waddr;
    writeData = wdata;
    readAddrA = ra;
    readAddrB = rb;
  endtask

  // Architectural view of a read during the current cycle.
  function automatic logic [WIDTH-1:0] refRead(input logic [ADDR_W-1:0] addr);
    if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && writeEn && writeAddr != 0 && writeAddr == addr) return writeData;
`endif
    return model[addr];
  endfunction

  // Advance one edge and commit the driven operation into the model.
  task automatic finishCycle();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (writeEn && writeAddr != 0) begin
      model[writeAddr] = writeData;
    end
    #1;
  endtask

  function automatic vec_t mkVec(input string name, input logic rst, input logic we,
                                 input int waddr, input logic [WIDTH-1:0] wdata,
                                 input int ra, input int rb,
                                 input logic [WIDTH-1:0] expA, input logic [WIDTH-1:0] expB);
    vec_t v;
    v.name  = name;
    v.rst   = rst;
    v.we    = we;
    v.waddr = ADDR_W'(waddr);
    v.wdata = wdata;
    v.ra    = ADDR_W'(ra);
    v.rb    = ADDR_W'(rb);
    v.expA  = expA;
    v.expB  = expB;
    return v;
  endfunction

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;

    // Directed table: expected values are what the read ports show before the edge.
`ifdef REGFILE_BYPASS_EN
    vecs.push_back(mkVec("wr_r5",      0, 1,  5, 32'hDEADBEEF,  5, 31, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mkVec("wr_r31",     0, 1, 31, 32'h12345678,  5, 31, 32'hDEADBEEF, 32'h12345678));
`else
    vecs.push_back(mkVec("wr_r5",      0, 1,  5, 32'hDEADBEEF,  5, 31, 32'h0,        32'h0));
    vecs.push_back(mkVec("wr_r31",     0, 1, 31, 32'h12345678,  5, 31, 32'hDEADBEEF, 32'h0));
`endif
    vecs.push_back(mkVec("readback",   0, 0,  0, 32'h0,         5, 31, 32'hDEADBEEF, 32'h12345678));
    vecs.push_back(mkVec("wr_r0",      0, 1,  0, 32'hFFFFFFFF,  0,  5, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mkVec("r0_after",   0, 0,  0, 32'h0,         0,  0, 32'h0,        32'h0));
`ifdef REGFILE_BYPASS_EN
    vecs.push_back(mkVec("wr_r7_1",    0, 1,  7, 32'h1,         7,  0, 32'h1,        32'h0));
    vecs.push_back(mkVec("wr_r7_2",    0, 1,  7, 32'h2,         7,  7, 32'h2,        32'h2));
`else
    vecs.push_back(mkVec("wr_r7_1",    0, 1,  7, 32'h1,         7,  0, 32'h0,        32'h0));
    vecs.push_back(mkVec("wr_r7_2",    0, 1,  7, 32'h2,         7,  7, 32'h1,        32'h1));
`endif
    vecs.push_back(mkVec("r7_next",    0, 0,  0, 32'h0,         7,  5, 32'h2,        32'hDEADBEEF));
    vecs.push_back(mkVec("rst_wr_r9",  1, 1,  9, 32'hAAAA5555,  9,  7, 32'h0,        32'h2));
    vecs.push_back(mkVec("post_rst",   0, 0,  0, 32'h0,         9,  7, 32'h0,        32'h0));
    vecs.push_back(mkVec("post_rst2",  0, 0,  0, 32'h0,         5, 31, 32'h0,        32'h0));
`ifdef REGFILE_BYPASS_EN
    vecs.push_back(mkVec("wr_r12",     0, 1, 12, 32'h0F0F0F0F, 12, 12, 32'h0F0F0F0F, 32'h0F0F0F0F));
`else
    vecs.push_back(mkVec("wr_r12",     0, 1, 12, 32'h0F0F0F0F, 12, 12, 32'h0,        32'h0));
`endif
    vecs.push_back(mkVec("dual_r12",   0, 0,  0, 32'h0,        12, 12, 32'h0F0F0F0F, 32'h0F0F0F0F));

    applyStimulus(1, 0, 0, 0, 0, 0);
    #1;
    finishCycle();
    finishCycle();

    $display("[TB] reset sweep of all addresses");
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(0, 0, 0, 0, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
      #2;
      checkOutput($sformatf("reset_a%0d", a), readDataA, 32'h0);
      checkOutput($sformatf("reset_b%0d", DEPTH - 1 - a), readDataB, 32'h0);
    end
    finishCycle();

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra, vecs[i].rb);
      #2;
      checkOutput({vecs[i].name, "_a"}, readDataA, vecs[i].expA);
      checkOutput({vecs[i].name, "_b"}, readDataB, vecs[i].expB);
      finishCycle();
    end

    $display("[TB] hold with write_en low and random address/data");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, ADDR_W'($urandom), $urandom, 12, 12);
      finishCycle();
      checkOutput($sformatf("hold_a%0d", c), readDataA, 32'h0F0F0F0F);
      checkOutput($sformatf("hold_b%0d", c), readDataB, 32'h0F0F0F0F);
    end

    $display("[TB] reset clears every entry");
    applyStimulus(0, 1, 3, 32'h33333333, 0, 0);
    finishCycle();
    applyStimulus(0, 1, 20, 32'h20202020, 3, 20);
    #2;
    checkOutput("pre_rst_r3", readDataA, 32'h33333333);
    finishCycle();
    applyStimulus(1, 1, 9, 32'hAAAA5555, 0, 0);
    finishCycle();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(0, 0, 0, 0, ADDR_W'(a), ADDR_W'(a));
      #2;
      checkOutput($sformatf("clr_a%0d", a), readDataA, 32'h0);
      checkOutput($sformatf("clr_b%0d", a), readDataB, 32'h0);
    end
    finishCycle();

    $display("[TB] random traffic against reference model");
    for (int c = 0; c < 600; c++) begin
      ra = ADDR_W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : ADDR_W'($urandom);
      applyStimulus(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                    ADDR_W'($urandom_range(0, 7)), $urandom, ra, rb);
      if ($urandom_range(0, 2) == 0) writeAddr = ra;
      #2;
      checkOutput($sformatf("rnd%0d_a", c), readDataA, refRead(readAddrA));
      checkOutput($sformatf("rnd%0d_b", c), readDataB, refRead(readAddrB));
      finishCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
